// File: rtl/dram_burst_xfer.sv
// dram_burst_xfer -- DRAM data-path burst engine.
//
// Sits between the controller's command sequencer and the DQ/DQS pad layer.
//
// Write path:
//   - Collects BURST_LEN controller words plus their byte masks into a buffer.
//   - Emits a one-cycle strobe preamble.
//   - Drives the burst on DQ/DQS/DM_n in wrapped column order, starting at col_start.
//
// Read path:
//   - Captures BURST_LEN PHY beats.
//   - Returns each beat one cycle later, tagged with its column.
//
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   wr_en, rd_en, col_start    burst start (sampled in IDLE only)
//   clear                      abort the burst in progress
//   memstore, store_mask,      write beat handshake
//     store_valid, store_ready
//   memload, load_col,         read beat to the controller
//     load_valid
//   busy                       engine not idle
//   dq_out, dq_oe, dqs_t,      pad-side write drive
//     dqs_c, dm_n
//   dq_in, dq_in_valid,        pad-side read capture
//     dbi_in_n
//
// Build option: define DRAM_XFER_DBI_EN to compile in write data-bus
// inversion (dm_n then carries DBI_n) and read de-inversion.
module dram_burst_xfer #(
  parameter int WORD_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int COL_W     = $clog2(BURST_LEN),
  parameter int MASK_W    = WORD_W / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clear,
  input  logic [COL_W-1:0]  col_start,
  input  logic [WORD_W-1:0] memstore,
  input  logic [MASK_W-1:0] store_mask,
  input  logic              store_valid,
  output logic              store_ready,
  output logic [WORD_W-1:0] memload,
  output logic [COL_W-1:0]  load_col,
  output logic              load_valid,
  output logic              busy,
  output logic [WORD_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              dqs_t,
  output logic              dqs_c,
  output logic [MASK_W-1:0] dm_n,
  input  logic [WORD_W-1:0] dq_in,
  input  logic              dq_in_valid,
  input  logic [MASK_W-1:0] dbi_in_n
);

  // One extra count bit so the drive phase can tell "all beats out" apart
  // from beat 0.
  localparam int               CNT_W     = COL_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] ALL_BEATS = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, WR_FILL, WR_PRE, WR_DRIVE, RD_CAP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [COL_W-1:0]  col_q;
  logic              store_ready_q;
  logic [WORD_W-1:0] memload_q;
  logic [COL_W-1:0]  load_col_q;
  logic              load_valid_q;
  logic              busy_q;
  logic [WORD_W-1:0] dq_out_q;
  logic              dq_oe_q;
  logic              dqs_t_q;
  logic              dqs_c_q;
  logic [MASK_W-1:0] dm_n_q;

  logic [WORD_W-1:0] data_mem [BURST_LEN];
  logic [COL_W-1:0]  col_d;
  logic [WORD_W-1:0] drv_word_d;
  logic [MASK_W-1:0] drv_mask_d;
  logic [WORD_W-1:0] rd_word_d;
  logic              store_we_d;

`ifdef DRAM_XFER_DBI_EN
  // A lane is kept as-is (flag 1) unless it has more than four zero bits.
  function automatic logic [MASK_W-1:0] dbi_keep(input logic [WORD_W-1:0] w);
    logic [MASK_W-1:0] f;
    for (int l = 0; l < MASK_W; l++) f[l] = ($countones(w[8*l +: 8]) >= 4);
    return f;
  endfunction

  function automatic logic [WORD_W-1:0] dbi_apply(input logic [WORD_W-1:0] w,
                                                  input logic [MASK_W-1:0] keep_n);
    logic [WORD_W-1:0] r;
    for (int l = 0; l < MASK_W; l++) r[8*l +: 8] = keep_n[l] ? w[8*l +: 8] : ~w[8*l +: 8];
    return r;
  endfunction

  logic unused_store_mask;
  assign unused_store_mask = ^store_mask;

  always_comb begin
    drv_mask_d = dbi_keep(data_mem[col_d]);
    drv_word_d = dbi_apply(data_mem[col_d], drv_mask_d);
    rd_word_d  = dbi_apply(dq_in, dbi_in_n);
  end
`else
  logic [MASK_W-1:0] mask_mem [BURST_LEN];
  logic              unused_dbi_in_n;
  assign unused_dbi_in_n = ^dbi_in_n;

  always_comb begin
    drv_word_d = data_mem[col_d];
    drv_mask_d = mask_mem[col_d];
    rd_word_d  = dq_in;
  end

  always_ff @(posedge CLK) begin
    if (store_we_d) mask_mem[cnt_q[COL_W-1:0]] <= store_mask;
  end
`endif

  // Column of the beat currently being driven or captured (wraps naturally).
  assign col_d      = col_q + cnt_q[COL_W-1:0];
  assign store_we_d = (state_q == WR_FILL) && store_ready_q && store_valid && !clear && !RST;

  always_ff @(posedge CLK) begin
    if (store_we_d) data_mem[cnt_q[COL_W-1:0]] <= memstore;
  end

  always_ff @(posedge CLK) begin
    // clear only acts on a burst in progress; in IDLE it merely blocks a start.
    if (RST || (clear && state_q != IDLE)) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      col_q         <= '0;
      store_ready_q <= 1'b0;
      memload_q     <= '0;
      load_col_q    <= '0;
      load_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      dq_out_q      <= '0;
      dq_oe_q       <= 1'b0;
      dqs_t_q       <= 1'b0;
      dqs_c_q       <= 1'b1;
      dm_n_q        <= '1;
    end else begin
      load_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!clear && wr_en) begin
            state_q       <= WR_FILL;
            store_ready_q <= 1'b1;
            busy_q        <= 1'b1;
            cnt_q         <= '0;
            col_q         <= col_start;
          end else if (!clear && rd_en) begin
            state_q <= RD_CAP;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            col_q   <= col_start;
          end
        end
        WR_FILL: begin
          if (store_valid) begin
            if (cnt_q == LAST_BEAT) begin
              // Preamble: strobe parked low, DQ quiet, all bytes enabled.
              state_q       <= WR_PRE;
              store_ready_q <= 1'b0;
              cnt_q         <= '0;
              dq_oe_q       <= 1'b1;
              dqs_t_q       <= 1'b0;
              dqs_c_q       <= 1'b1;
              dq_out_q      <= '0;
              dm_n_q        <= '1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        WR_PRE, WR_DRIVE: begin
          if (state_q == WR_DRIVE && cnt_q == ALL_BEATS) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            dq_oe_q  <= 1'b0;
            dqs_t_q  <= 1'b0;
            dqs_c_q  <= 1'b1;
            dq_out_q <= '0;
            dm_n_q   <= '1;
          end else begin
            state_q  <= WR_DRIVE;
            dq_out_q <= drv_word_d;
            dm_n_q   <= drv_mask_d;
            dqs_t_q  <= ~cnt_q[0];
            dqs_c_q  <= cnt_q[0];
            cnt_q    <= cnt_q + CNT_ONE;
          end
        end
        RD_CAP: begin
          if (dq_in_valid) begin
            memload_q    <= rd_word_d;
            load_col_q   <= col_d;
            load_valid_q <= 1'b1;
            if (cnt_q == LAST_BEAT) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign store_ready = store_ready_q;
  assign memload     = memload_q;
  assign load_col    = load_col_q;
  assign load_valid  = load_valid_q;
  assign busy        = busy_q;
  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign dqs_t       = dqs_t_q;
  assign dqs_c       = dqs_c_q;
  assign dm_n        = dm_n_q;

endmodule

// File: tb/tb_dram_burst_xfer.sv
// Directed testbench for dram_burst_xfer (default build, BURST_LEN=8, WORD_W=32).
module tb_dram_burst_xfer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0, clear = 1'b0;
  logic [2:0]  col_start = '0;
  logic [31:0] memstore = '0;
  logic [3:0]  store_mask = '0;
  logic        store_valid = 1'b0;
  logic        store_ready;
  logic [31:0] memload;
  logic [2:0]  load_col;
  logic        load_valid, busy;
  logic [31:0] dq_out;
  logic        dq_oe, dqs_t, dqs_c;
  logic [3:0]  dm_n;
  logic [31:0] dq_in = '0;
  logic        dq_in_valid = 1'b0;
  logic [3:0]  dbi_in_n = '1;

  int n_cmp = 0;
  int n_err = 0;

  dram_burst_xfer #(.WORD_W(32), .BURST_LEN(8)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .rd_en(rd_en), .clear(clear),
    .col_start(col_start), .memstore(memstore), .store_mask(store_mask),
    .store_valid(store_valid), .store_ready(store_ready), .memload(memload),
    .load_col(load_col), .load_valid(load_valid), .busy(busy), .dq_out(dq_out),
    .dq_oe(dq_oe), .dqs_t(dqs_t), .dqs_c(dqs_c), .dm_n(dm_n), .dq_in(dq_in),
    .dq_in_valid(dq_in_valid), .dbi_in_n(dbi_in_n)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start a write burst and deliver 8 back-to-back beats base+n with full masks.
  // Returns in the WR_PRE cycle.
  task automatic fill_burst(input logic [31:0] base, input logic [2:0] col);
    wr_en = 1'b1; col_start = col;
    tick();
    wr_en = 1'b0;
    for (int n = 0; n < 8; n++) begin
      store_valid = 1'b1; memstore = base + 32'(n); store_mask = 4'hF;
      tick();
    end
    store_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({store_ready, load_valid, busy, dq_oe, dqs_t, dqs_c, dm_n} !== 10'b0000_01_1111) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b need %b",
               {store_ready, load_valid, busy, dq_oe, dqs_t, dqs_c, dm_n}, 10'b0000011111);
    end
    n_cmp++;
    if ({memload, load_col, dq_out} !== 67'd0) begin
      n_err++;
      $display("FAIL reset_data: got memload=%h load_col=%0d dq_out=%h need all zero",
               memload, load_col, dq_out);
    end
    RST = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b need 0", busy);
    end
  endtask

  task automatic test_write_basic();
    logic [31:0] exp_w;
    wr_en = 1'b1; col_start = 3'd3;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if ({store_ready, busy, dq_oe} !== 3'b110) begin
      n_err++;
      $display("FAIL wr_start: got ready,busy,oe=%b need 110", {store_ready, busy, dq_oe});
    end
    for (int n = 0; n < 8; n++) begin
      store_valid = 1'b1; memstore = 32'h100 + 32'(n); store_mask = 4'hF;
      tick();
    end
    store_valid = 1'b0;
    n_cmp++;
    if ({store_ready, busy, dq_oe, dqs_t, dqs_c, dm_n, dq_out} !== {5'b01101, 4'hF, 32'h0}) begin
      n_err++;
      $display("FAIL wr_preamble: got ready=%b busy=%b oe=%b t=%b c=%b dm=%b dq=%h need 0 1 1 0 1 1111 0",
               store_ready, busy, dq_oe, dqs_t, dqs_c, dm_n, dq_out);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      exp_w = 32'h100 + 32'((3 + k) % 8);
      n_cmp++;
      if ({dq_out, dm_n, dq_oe, dqs_t, dqs_c, busy} !==
          {exp_w, 4'hF, 1'b1, (k % 2 == 0), (k % 2 != 0), 1'b1}) begin
        n_err++;
        $display("FAIL wr_beat%0d: got dq=%h dm=%b oe=%b t=%b c=%b busy=%b need dq=%h dm=1111 oe=1 t=%b c=%b busy=1",
                 k, dq_out, dm_n, dq_oe, dqs_t, dqs_c, busy, exp_w, (k % 2 == 0), (k % 2 != 0));
      end
      tick();
    end
    n_cmp++;
    if ({busy, dq_oe, dqs_t, dqs_c, dm_n, dq_out} !== {4'b0001, 4'hF, 32'h0}) begin
      n_err++;
      $display("FAIL wr_end: got busy=%b oe=%b t=%b c=%b dm=%b dq=%h need 0 0 0 1 1111 0",
               busy, dq_oe, dqs_t, dqs_c, dm_n, dq_out);
    end
  endtask

  task automatic test_write_stall();
    logic [31:0] exp_w;
    logic [3:0]  exp_m;
    int          col;
    wr_en = 1'b1; col_start = 3'd5;
    tick();
    wr_en = 1'b0;
    // Valid on even cycles only; odd cycles carry junk data that must not be stored.
    for (int i = 0; i < 15; i++) begin
      store_valid = (i % 2 == 0);
      memstore    = (i % 2 == 0) ? 32'h200 + 32'(i / 2) : 32'hDEAD_0000 + 32'(i);
      store_mask  = (i / 2 == 2 && i % 2 == 0) ? 4'b0101 : 4'b0000;
      if (i % 2 == 0 && i / 2 != 2) store_mask = 4'hF;
      tick();
    end
    // A beat offered while store_ready=0 must be ignored.
    store_valid = 1'b1; memstore = 32'hBAD0_BAD0; store_mask = 4'h0;
    n_cmp++;
    if ({store_ready, dq_oe, dqs_t} !== 3'b010) begin
      n_err++;
      $display("FAIL stall_pre: got ready,oe,t=%b need 010", {store_ready, dq_oe, dqs_t});
    end
    tick();
    store_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      col   = (5 + k) % 8;
      exp_w = 32'h200 + 32'(col);
      exp_m = (col == 2) ? 4'b0101 : 4'hF;
      n_cmp++;
      if ({dq_out, dm_n} !== {exp_w, exp_m}) begin
        n_err++;
        $display("FAIL stall_beat%0d: got dq=%h dm=%b need dq=%h dm=%b", k, dq_out, dm_n, exp_w, exp_m);
      end
      tick();
    end
    n_cmp++;
    if ({busy, dq_oe} !== 2'b00) begin
      n_err++;
      $display("FAIL stall_end: got busy,oe=%b need 00", {busy, dq_oe});
    end
  endtask

  task automatic test_read();
    rd_en = 1'b1; col_start = 3'd6;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({busy, load_valid, store_ready, dq_oe} !== 4'b1000) begin
      n_err++;
      $display("FAIL rd_start: got busy,lv,ready,oe=%b need 1000", {busy, load_valid, store_ready, dq_oe});
    end
    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < (b % 3); g++) begin
        dq_in = 32'hFFFF_FFFF;
        tick();
        n_cmp++;
        if (load_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rd_gap%0d: got load_valid=%b need 0", b, load_valid);
        end
      end
      dq_in_valid = 1'b1; dq_in = 32'hA0 + 32'(b);
      tick();
      dq_in_valid = 1'b0;
      n_cmp++;
      if ({load_valid, memload, load_col, busy} !== {1'b1, 32'hA0 + 32'(b), 3'((6 + b) % 8), (b != 7)}) begin
        n_err++;
        $display("FAIL rd_beat%0d: got lv=%b data=%h col=%0d busy=%b need 1 %h %0d %b",
                 b, load_valid, memload, load_col, busy, 32'hA0 + 32'(b), (6 + b) % 8, (b != 7));
      end
    end
    // Read data offered while idle must not produce a beat.
    dq_in_valid = 1'b1; dq_in = 32'h5555_5555;
    tick();
    dq_in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({load_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL rd_idle_ignore: got lv,busy=%b need 00", {load_valid, busy});
    end
  endtask

  task automatic test_both_start();
    int lv_seen = 0;
    wr_en = 1'b1; rd_en = 1'b1; col_start = 3'd0;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_cmp++;
    if ({store_ready, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL both_start: got ready,busy=%b need 11", {store_ready, busy});
    end
    for (int n = 0; n < 8; n++) begin
      store_valid = 1'b1; memstore = 32'h300 + 32'(n); store_mask = 4'hF;
      dq_in_valid = 1'b1; dq_in = 32'h7777_0000 + 32'(n);
      if (load_valid) lv_seen++;
      tick();
    end
    store_valid = 1'b0;
    dq_in_valid = 1'b0;
    tick();
    n_cmp++;
    if (dq_out !== 32'h300) begin
      n_err++;
      $display("FAIL both_beat0: got dq=%h need 00000300", dq_out);
    end
    for (int k = 0; k < 9; k++) begin
      if (load_valid) lv_seen++;
      tick();
    end
    n_cmp++;
    if (lv_seen !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL both_no_read: got load_valid pulses=%0d busy=%b need 0 0", lv_seen, busy);
    end
  endtask

  task automatic test_clear();
    // Clear during drive beat 4.
    fill_burst(32'h400, 3'd0);
    tick();
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if (dq_out !== 32'h404) begin
      n_err++;
      $display("FAIL clr_beat4: got dq=%h need 00000404", dq_out);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++;
    if ({dq_oe, busy, dqs_t, dqs_c, dm_n, dq_out, store_ready} !== {4'b0001, 4'hF, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL clr_drive: got oe=%b busy=%b t=%b c=%b dm=%b dq=%h ready=%b need 0 0 0 1 1111 0 0",
               dq_oe, busy, dqs_t, dqs_c, dm_n, dq_out, store_ready);
    end
    // Clear mid-fill discards the count: the next burst needs all 8 beats again.
    wr_en = 1'b1; col_start = 3'd0;
    tick();
    wr_en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      store_valid = 1'b1; memstore = 32'hEE; store_mask = 4'hF;
      tick();
    end
    store_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    for (int n = 0; n < 7; n++) begin
      store_valid = 1'b1; memstore = 32'h500 + 32'(n); store_mask = 4'hF;
      tick();
    end
    store_valid = 1'b0;
    n_cmp++;
    if ({store_ready, dq_oe} !== 2'b10) begin
      n_err++;
      $display("FAIL clr_fill_count: got ready,oe=%b need 10 after 7 beats", {store_ready, dq_oe});
    end
    store_valid = 1'b1; memstore = 32'h507;
    tick();
    store_valid = 1'b0;
    tick();
    n_cmp++;
    if (dq_out !== 32'h500) begin
      n_err++;
      $display("FAIL clr_refill_beat0: got dq=%h need 00000500", dq_out);
    end
    for (int k = 0; k < 8; k++) tick();
    // Clear after the third read capture.
    rd_en = 1'b1; col_start = 3'd2;
    tick();
    rd_en = 1'b0;
    for (int b = 0; b < 3; b++) begin
      dq_in_valid = 1'b1; dq_in = 32'hC0 + 32'(b);
      tick();
    end
    n_cmp++;
    if ({load_valid, memload, load_col} !== {1'b1, 32'hC2, 3'd4}) begin
      n_err++;
      $display("FAIL clr_rd_cap3: got lv=%b data=%h col=%0d need 1 000000c2 4", load_valid, memload, load_col);
    end
    clear = 1'b1; dq_in = 32'hC3;
    tick();
    clear = 1'b0;
    n_cmp++;
    if ({load_valid, busy, memload, load_col, dm_n} !== {2'b00, 32'h0, 3'd0, 4'hF}) begin
      n_err++;
      $display("FAIL clr_read: got lv=%b busy=%b data=%h col=%0d dm=%b need 0 0 0 0 1111",
               load_valid, busy, memload, load_col, dm_n);
    end
    tick(); tick();
    dq_in_valid = 1'b0;
    n_cmp++;
    if ({load_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL clr_read_after: got lv,busy=%b need 00", {load_valid, busy});
    end
    // Clear together with a start in IDLE drops the start.
    clear = 1'b1; wr_en = 1'b1;
    tick();
    clear = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if ({busy, store_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL clr_start: got busy,ready=%b need 00", {busy, store_ready});
    end
  endtask

  task automatic test_reset_midburst();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    dq_in_valid = 1'b1; dq_in = 32'h1;
    tick();
    RST = 1'b1; clear = 1'b1;
    tick();
    RST = 1'b0; clear = 1'b0; dq_in_valid = 1'b0;
    n_cmp++;
    if ({busy, load_valid, memload} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL rst_mid: got busy=%b lv=%b data=%h need 0 0 0", busy, load_valid, memload);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_stall();
    test_read();
    test_both_start();
    test_clear();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
